tdm_demux8: RTL and testbench

- Receive side of the 8:1 channel multiplexer: a 1:8 time-division demultiplexer.
- The transmitter serialises channels Y0..Y7 onto one line, one slot per accepted beat, with a sync flag on slot 0.
- This block tracks slot position, collects a full frame, and presents all eight channels together on registered outputs with a one-cycle frame strobe.
- It sits between the serial link and the per-channel consumers, and detects loss of frame alignment.

---
 rtl/tdm_pkg.sv | 20 ++
 rtl/tdm_slot_tracker.sv | 75 +++++++
 rtl/tdm_demux8.sv | 85 ++++++++
 tb/tb_tdm_demux8.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// Shared TDM definitions used by both the transmit-side mux/serialiser and the
// receive-side demux, so slot numbering agrees end to end.
//   NUM_SLOTS : channels per frame
//   SLOT_W    : width of a slot index
//   state_t   : receive framer state (HUNT = searching for sync, RUN = aligned)
package tdm_pkg;

  localparam int unsigned NUM_SLOTS = 8;
  localparam int unsigned SLOT_W    = 3;

  typedef logic [SLOT_W-1:0] slot_t;

  localparam slot_t LAST_SLOT = slot_t'(NUM_SLOTS - 1);

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/tdm_slot_tracker.sv
// Frame alignment tracker for the TDM receiver.
// Owns the HUNT/RUN state, the slot counter and sync checking.
//   clk, rst    : clock, asynchronous active-high reset
//   in_valid    : beat accepted this cycle
//   sync        : beat is marked as slot 0 (qualified by in_valid)
//   wr_en       : store the current beat into slot wr_slot (same cycle)
//   wr_slot     : slot index of the current beat
//   frame_done  : current beat completes a frame (slot 7, no sync)
//   slot        : slot the next accepted beat fills (0 in HUNT)
//   locked      : high while in RUN
//   sync_err    : one-cycle registered pulse after an alignment error
module tdm_slot_tracker
  import tdm_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  in_valid,
  input  logic  sync,
  output logic  wr_en,
  output slot_t wr_slot,
  output logic  frame_done,
  output slot_t slot,
  output logic  locked,
  output logic  sync_err
);

  state_t state;
  logic   early_sync;
  logic   missing_sync;

  // Per-beat decode. An early sync restarts the frame at slot 0; a missing
  // sync drops the beat and falls back to HUNT.
  always_comb begin
    wr_en        = 1'b0;
    wr_slot      = '0;
    frame_done   = 1'b0;
    early_sync   = 1'b0;
    missing_sync = 1'b0;
    if (in_valid) begin
      if (state == HUNT) begin
        wr_en = sync;
      end else if (slot == '0) begin
        if (sync) wr_en = 1'b1;
        else      missing_sync = 1'b1;
      end else if (sync) begin
        early_sync = 1'b1;
        wr_en      = 1'b1;
      end else begin
        wr_en      = 1'b1;
        wr_slot    = slot;
        frame_done = (slot == LAST_SLOT);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= HUNT;
      slot     <= '0;
      sync_err <= 1'b0;
    end else begin
      sync_err <= early_sync | missing_sync;
      if (missing_sync) begin
        state <= HUNT;
        slot  <= '0;
      end else if (wr_en) begin
        state <= RUN;
        slot  <= wr_slot + 1'b1;  // 3-bit wrap takes slot 7 back to 0
      end
    end
  end

  assign locked = (state == RUN);

endmodule

// File: rtl/tdm_demux8.sv
// 1:8 time-division demultiplexer (receive side of the 8:1 channel mux).
// Collects one frame of serial samples and presents all eight channels
// together on registered outputs with a one-cycle frame strobe.
//   clk, rst     : clock, asynchronous active-high reset
//   din          : serial sample for the current slot
//   in_valid     : beat accepted this cycle (no backpressure)
//   sync         : beat is slot 0 (qualified by in_valid)
//   Y0..Y7       : channel outputs of the last complete frame
//   frame_valid  : one-cycle pulse when Y0..Y7 update
//   slot         : slot index the next accepted beat fills
//   locked       : frame alignment held (RUN)
//   sync_err     : one-cycle pulse on an alignment error
module tdm_demux8
  import tdm_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             in_valid,
  input  logic             sync,
  output logic [WIDTH-1:0] Y0,
  output logic [WIDTH-1:0] Y1,
  output logic [WIDTH-1:0] Y2,
  output logic [WIDTH-1:0] Y3,
  output logic [WIDTH-1:0] Y4,
  output logic [WIDTH-1:0] Y5,
  output logic [WIDTH-1:0] Y6,
  output logic [WIDTH-1:0] Y7,
  output logic             frame_valid,
  output logic [2:0]       slot,
  output logic             locked,
  output logic             sync_err
);

  logic  wr_en;
  slot_t wr_slot;
  logic  frame_done;

  // Slot 7 is never stored: it goes straight to Y7 on completion.
  logic [WIDTH-1:0] shadow [0:NUM_SLOTS-2];

  tdm_slot_tracker u_tracker (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .sync       (sync),
    .wr_en      (wr_en),
    .wr_slot    (wr_slot),
    .frame_done (frame_done),
    .slot       (slot),
    .locked     (locked),
    .sync_err   (sync_err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_SLOTS - 1; i++) shadow[i] <= '0;
      Y0          <= '0;
      Y1          <= '0;
      Y2          <= '0;
      Y3          <= '0;
      Y4          <= '0;
      Y5          <= '0;
      Y6          <= '0;
      Y7          <= '0;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= frame_done;
      if (wr_en && (wr_slot != LAST_SLOT)) shadow[wr_slot] <= din;
      if (frame_done) begin
        Y0 <= shadow[0];
        Y1 <= shadow[1];
        Y2 <= shadow[2];
        Y3 <= shadow[3];
        Y4 <= shadow[4];
        Y5 <= shadow[5];
        Y6 <= shadow[6];
        Y7 <= din;
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux8.sv
module tb_tdm_demux8;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] din = '0;
  logic         in_valid = 1'b0;
  logic         sync = 1'b0;
  logic [W-1:0] Y0, Y1, Y2, Y3, Y4, Y5, Y6, Y7;
  logic         frame_valid;
  logic [2:0]   slot;
  logic         locked;
  logic         sync_err;
  logic [31:0]  ycat;

  int n_checks = 0;
  int n_err    = 0;

  tdm_demux8 #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .din(din), .in_valid(in_valid), .sync(sync),
    .Y0(Y0), .Y1(Y1), .Y2(Y2), .Y3(Y3), .Y4(Y4), .Y5(Y5), .Y6(Y6), .Y7(Y7),
    .frame_valid(frame_valid), .slot(slot), .locked(locked), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  assign ycat = {Y7, Y6, Y5, Y4, Y3, Y2, Y1, Y0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: frame alignment expressed directly as rules on a
  // partial-frame array and an expected slot number.
  int m_part [8];
  int m_y    [8];
  int m_slot;
  bit m_lock, m_fv, m_err;

  always @(posedge clk or posedge rst) begin : model
    int p [8];
    int y [8];
    int s;
    bit lk, fv, er;
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        m_part[i] <= 0;
        m_y[i]    <= 0;
      end
      m_slot <= 0;
      m_lock <= 1'b0;
      m_fv   <= 1'b0;
      m_err  <= 1'b0;
    end else begin
      p = m_part; y = m_y; s = m_slot; lk = m_lock; fv = 1'b0; er = 1'b0;
      if (in_valid) begin
        if (!lk) begin
          if (sync) begin p[0] = int'(din); s = 1; lk = 1'b1; end
        end else if (sync && s != 0) begin
          er = 1'b1; p[0] = int'(din); s = 1;
        end else if (!sync && s == 0) begin
          er = 1'b1; lk = 1'b0;
        end else begin
          p[s] = int'(din);
          if (s == 7) begin y = p; fv = 1'b1; s = 0; end
          else s = s + 1;
        end
      end
      m_part <= p; m_y <= y; m_slot <= s; m_lock <= lk; m_fv <= fv; m_err <= er;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    logic [31:0] my;
    if (!rst) begin
      for (int i = 0; i < 8; i++) my[i*4 +: 4] = 4'(m_y[i]);
      check("cyc_y", ycat, my);
      check("cyc_frame_valid", 32'(frame_valid), 32'(m_fv));
      check("cyc_sync_err", 32'(sync_err), 32'(m_err));
      check("cyc_locked", 32'(locked), 32'(m_lock));
      check("cyc_slot", 32'(slot), 32'(m_slot));
    end
  end

  // frame_valid pulse log (cycle numbers) for spacing checks.
  int cyc = 0;
  int fv_cyc [$];
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (!rst && frame_valid) fv_cyc.push_back(cyc);
  end

  task automatic beat(input bit s, input int d);
    in_valid = 1'b1; sync = s; din = 4'(d);
    @(posedge clk); #1;
    in_valid = 1'b0; sync = 1'b0;
  endtask

  task automatic idle();
    in_valid = 1'b0; sync = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int base;
    // Reset release, then beats without sync are ignored.
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    check("rst_y", ycat, 32'h0);
    check("rst_locked", 32'(locked), 32'd0);
    for (int i = 0; i < 8; i++) beat(1'b0, i + 3);
    check("nosync_locked", 32'(locked), 32'd0);
    check("nosync_slot", 32'(slot), 32'd0);
    check("nosync_y", ycat, 32'h0);

    // Clean frame 1..8, then 8..1 back-to-back.
    for (int i = 0; i < 8; i++) beat(i == 0, i + 1);
    check("clean_fv", 32'(frame_valid), 32'd1);
    check("clean_y", ycat, 32'h87654321);
    for (int i = 0; i < 8; i++) beat(i == 0, 8 - i);
    check("b2b_fv", 32'(frame_valid), 32'd1);
    check("b2b_y", ycat, 32'h12345678);

    // Gapped frame: 3 idle cycles between slots 3 and 4.
    for (int i = 0; i < 4; i++) beat(i == 0, i + 1);
    for (int g = 0; g < 3; g++) begin
      idle();
      check("gap_slot", 32'(slot), 32'd4);
      check("gap_fv", 32'(frame_valid), 32'd0);
    end
    for (int i = 4; i < 8; i++) beat(1'b0, i + 1);
    check("gap_fv_end", 32'(frame_valid), 32'd1);
    check("gap_y", ycat, 32'h87654321);

    // Early sync at slot 5.
    for (int i = 0; i < 5; i++) beat(i == 0, 10);
    beat(1'b1, 3);
    check("early_err", 32'(sync_err), 32'd1);
    check("early_y_held", ycat, 32'h87654321);
    check("early_slot", 32'(slot), 32'd1);
    check("early_locked", 32'(locked), 32'd1);
    for (int i = 0; i < 7; i++) beat(1'b0, i + 4);
    check("early_fv", 32'(frame_valid), 32'd1);
    check("early_y", ycat, 32'hA9876543);

    // Missing sync at slot 0.
    beat(1'b0, 5);
    check("miss_err", 32'(sync_err), 32'd1);
    check("miss_locked", 32'(locked), 32'd0);
    for (int i = 0; i < 3; i++) beat(1'b0, 9);
    check("miss_slot", 32'(slot), 32'd0);
    beat(1'b1, 2);
    for (int i = 1; i < 7; i++) beat(1'b0, 2 * (i + 1));
    beat(1'b0, 1);
    check("resume_y", ycat, 32'h1ECA8642);

    // Three consecutive frames: slot sequence and pulse spacing.
    idle();
    base = fv_cyc.size();
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < 8; i++) begin
        check("wrap_slot", 32'(slot), 32'(i));
        beat(i == 0, (f * 8 + i + 1) % 16);
      end
    idle();
    check("wrap_count", 32'(fv_cyc.size() - base), 32'd3);
    if (fv_cyc.size() - base == 3) begin
      check("wrap_gap1", 32'(fv_cyc[base+1] - fv_cyc[base]), 32'd8);
      check("wrap_gap2", 32'(fv_cyc[base+2] - fv_cyc[base+1]), 32'd8);
    end

    // Reset mid-frame discards the partial frame at once.
    for (int i = 0; i < 3; i++) beat(i == 0, 7);
    #3 rst = 1'b1;
    #1;
    check("mrst_y", ycat, 32'h0);
    check("mrst_fv", 32'(frame_valid), 32'd0);
    check("mrst_locked", 32'(locked), 32'd0);
    check("mrst_slot", 32'(slot), 32'd0);
    check("mrst_err", 32'(sync_err), 32'd0);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) beat(1'b0, 6);
    check("mrst_hunt", 32'(locked), 32'd0);
    for (int i = 0; i < 8; i++) beat(i == 0, i + 1);
    check("mrst_resume_y", ycat, 32'h87654321);
    idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
